ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte from the FPGA to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable scanning). It implements the request-to-send sequence, shifts data on device-generated clock edges and collects the device acknowledge. It sits beside the PS/2 receive path under the top level and drives the PS2_CLK/PS2_DAT pins through open-drain enables.

Parameters:
INHIBIT_CYCLES, 5000, clock-low request-to-send hold time (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, max wait from clock release to first device falling edge (15 ms).
BIT_TIMEOUT_CYCLES, 100000, max gap between consecutive device falling edges (2 ms).

Ports:
clock  input  1  system clock (50 MHz).
reset  input  1  synchronous, active-high reset.
cmd_data  input  8  command byte, sampled when cmd_valid && cmd_ready.
cmd_valid  input  1  request to send cmd_data.
cmd_ready  output  1  high only in IDLE.
ps2_clk_in  input  1  raw PS2_CLK pin level (asynchronous).
ps2_dat_in  input  1  raw PS2_DAT pin level (asynchronous).
ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release the line.
ps2_dat_oe  output  1  1 = pull PS2_DAT low; 0 = release the line.
busy  output  1  high in every state except IDLE.
cmd_done  output  1  one-cycle pulse on successful completion.
cmd_error  output  1  one-cycle pulse on timeout or NACK; mutually exclusive with cmd_done.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, cmd_done=0, cmd_error=0, busy=0, cmd_ready=1.
- Reset asserted mid-transfer releases both lines on the next edge and discards the byte.
- Pin inputs pass through a 2-flop synchronizer. A falling edge (fe) is sync_prev=1 && sync_now=0, so detection latency is 3 cycles.
- Handshake: on cmd_valid && cmd_ready, the block latches the byte and computes odd parity (~^cmd_data). The next state is INHIBIT. cmd_valid is ignored while busy.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. ps2_dat_oe is set to 1 in the last INHIBIT cycle (start bit = 0). The next state is RELEASE.
- RELEASE: ps2_clk_oe=0 and ps2_dat_oe stays 1. Counter starts at 0.
  - On fe: go to SHIFT with bit index 0, drive data bit 0, reset the counter.
  - On counter reaching START_TIMEOUT_CYCLES: go to ERROR.
- SHIFT: on each fe, drive the next frame bit: data[idx] LSB first for idx 0..7, then parity at idx 8, then the stop bit at idx 9.
  - Drive rule: ps2_dat_oe = ~bit (logic 0 pulls low, 1 releases).
  - On the fe after the stop bit, go to ACK.
  - Counter restarts at every fe; reaching BIT_TIMEOUT_CYCLES goes to ERROR.
- ACK: ps2_dat_oe=0. On the next fe, sample synchronized data; 0 = ACK. Then go to WAIT_IDLE. Timeout as in SHIFT.
- WAIT_IDLE: wait for synchronized clock=1 and data=1 for 2 consecutive cycles, then go to DONE. Timeout as in SHIFT.
- DONE: cmd_done=1 for one cycle, then IDLE.
- ERROR: release both lines, cmd_error=1 for one cycle, then IDLE.
- Counters are sized for the largest timeout (20 bits at defaults) and saturate; they never wrap.
- A single bit index counter 0..10 is used; index 10 is the ACK state.
- If fe and timeout occur in the same cycle, fe wins.

Optional Feature:
PS2_TX_ACK_CHECK_EN.
- Defined: a sampled ACK bit of 1 (NACK) routes to ERROR instead of WAIT_IDLE.
- Undefined: the ACK level is ignored; any fe in ACK proceeds to WAIT_IDLE. Timeouts still apply.

Decomposition:
- Package ps2_pkg holds:
  - the state enum IDLE/INHIBIT/RELEASE/SHIFT/ACK/WAIT_IDLE/DONE/ERROR;
  - frame constants: FRAME_DATA_BITS=8, PARITY_IDX=8, STOP_IDX=9, ACK_IDX=10;
  - common scancode/command constants (0xED, 0xF4, 0xFF), shared with the receive path.
- Sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detector, instantiated once each for clock and data.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and ACK=0 → ps2_clk_oe high for exactly 5000 cycles; line bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one cmd_done pulse; lines released.
- Send 0xED → data bits 1,0,1,1,0,1,1,1, parity 1; cmd_done after WAIT_IDLE.
- No device clock after RELEASE → cmd_error exactly 750000 cycles after clock release; cmd_done never pulses.
- Device stops after the 4th fe → cmd_error 100000 cycles after that edge; both oe outputs 0.
- Reset asserted mid-SHIFT at bit 5 → next cycle: oe=0,0, busy=0, cmd_ready=1; no done/error pulse.
- Device returns ACK=1: with PS2_TX_ACK_CHECK_EN → cmd_error; without it → cmd_done. cmd_valid pulses while busy are ignored in both builds.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types and constants for the host transmit and receive paths.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ps2_pkg;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RELEASE   = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } ps2_tx_state_e;

  // Frame layout: 8 data bits LSB first, odd parity, stop, then the device ACK slot.
  localparam int FRAME_DATA_BITS = 8;
  localparam int IDX_W           = 4;
  localparam logic [IDX_W-1:0] PARITY_IDX = 4'd8;
  localparam logic [IDX_W-1:0] STOP_IDX   = 4'd9;
  localparam logic [IDX_W-1:0] ACK_IDX    = 4'd10;

  // Common keyboard commands / responses.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Largest of three cycle counts; sizes the shared timeout counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

  // Logic level of frame bit idx (0..7 data, 8 parity, 9 stop).
  function automatic logic frame_bit(input logic [FRAME_DATA_BITS-1:0] d, input logic par,
                                     input logic [IDX_W-1:0] idx);
    logic b;
    b = 1'b1;
    if (idx < PARITY_IDX) begin
      b = d[idx[2:0]];
    end else if (idx == PARITY_IDX) begin
      b = par;
    end
    return b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for one raw PS/2 pin plus a falling-edge detector.
// Latency: level_o lags the pin by 2 cycles; fe_o is high in the cycle after that (acted on at the 3rd edge).
// Backpressure: none; free-running on every cycle.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resynchronize the pin and keep one cycle of history; reset to the idle-high level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fe_o    = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (request-to-send, shift on device clock, ACK).
// Latency: INHIBIT_CYCLES of clock hold, then paced by the device clock; pin edges seen 3 cycles late.
// Backpressure: cmd_ready only in IDLE; cmd_valid ignored while busy. Define PS2_TX_ACK_CHECK_EN to treat NACK as error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 5000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_error
);

  // One counter serves the inhibit hold and all three timeouts, so it is sized for the largest.
  localparam int unsigned CNT_TOP = max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES, BIT_TIMEOUT_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  ps2_tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [FRAME_DATA_BITS-1:0] data_q, data_d;
  logic                       par_q, par_d;
  logic                       quiet_q, quiet_d;
  logic                       clk_oe_q, clk_oe_d;
  logic                       dat_oe_q, dat_oe_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic             clk_lvl, clk_fe;
  logic             dat_lvl, dat_fe;
  logic [CNT_W-1:0] cnt_inc;
  logic             line_quiet;

  ps2_line_sync u_clk_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .pin_i   (ps2_clk_in),
    .level_o (clk_lvl),
    .fe_o    (clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .pin_i   (ps2_dat_in),
    .level_o (dat_lvl),
    .fe_o    (dat_fe)
  );

  // Saturating increment: a stuck counter must never wrap back under a timeout limit.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // Both lines high and no edge in flight counts toward the bus-idle run.
  assign line_quiet = clk_lvl & dat_lvl & ~clk_fe & ~dat_fe;

  // Next-state logic plus next values of the registered pin enables and status pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    quiet_d  = quiet_q;
    clk_oe_d = 1'b0;
    dat_oe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = INHIBIT;
          data_d  = cmd_data;
          par_d   = odd_parity(cmd_data);
          cnt_d   = '0;
          idx_d   = '0;
          quiet_d = 1'b0;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RELEASE: begin
        // A device edge beats a timeout landing in the same cycle.
        if (clk_fe) begin
          state_d = SHIFT;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == START_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      SHIFT: begin
        if (clk_fe) begin
          cnt_d = '0;
          if (idx_q == STOP_IDX) begin
            state_d = ACK;
            idx_d   = ACK_IDX;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (cnt_q == BIT_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ACK: begin
        if (clk_fe) begin
          cnt_d   = '0;
          quiet_d = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
          // Device leaves data high on NACK.
          state_d = dat_lvl ? ERROR : WAIT_IDLE;
`else
          state_d = WAIT_IDLE;
`endif
        end else if (cnt_q == BIT_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_IDLE: begin
        // Two consecutive quiet cycles mean the device has released the bus.
        if (line_quiet && quiet_q) begin
          state_d = DONE;
        end else if (cnt_q == BIT_LAST) begin
          state_d = ERROR;
        end else begin
          quiet_d = line_quiet;
          cnt_d   = cnt_inc;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERROR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin enables follow the state being entered so they change together with it.
    clk_oe_d = (state_d == INHIBIT);
    case (state_d)
      INHIBIT: dat_oe_d = (cnt_d == INH_LAST);
      RELEASE: dat_oe_d = 1'b1;
      SHIFT:   dat_oe_d = ~frame_bit(data_d, par_d, idx_d);
      default: dat_oe_d = 1'b0;
    endcase
    done_d = (state_d == DONE);
    err_d  = (state_d == ERROR);
  end

  // State, counters and registered outputs; reset releases both lines and drops the byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      quiet_q  <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      quiet_q  <= quiet_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign cmd_done   = done_q;
  assign cmd_error  = err_q;
  assign busy       = (state_q != IDLE);
  assign cmd_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a PS/2 keyboard model on open-drain pins.
// Timeouts are scaled down so every scenario fits in a short run; device clock is a scaled 12.5 kHz.
// Expected frames come from a byte-level model (LSB-first data, odd parity, stop bit).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH      = 40;
  localparam int ST_TO    = 600;
  localparam int BIT_TO   = 300;
  localparam int SYNC_LAT = 3;

  logic       clock;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       cmd_done;
  logic       cmd_error;

  // Device-side drivers: 1 releases the line, 0 pulls it low.
  logic dev_clk;
  logic dev_dat;

  int n_chk;
  int n_fail;
  int m_clkoe;
  int m_start;
  int m_done;
  int m_err;
  int m_both;

  // Open-drain bus with pull-ups.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (ST_TO),
    .BIT_TIMEOUT_CYCLES   (BIT_TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .cmd_done   (cmd_done),
    .cmd_error  (cmd_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cumulative activity counters, sampled away from the active edge.
  initial begin
    m_clkoe = 0;
    m_start = 0;
    m_done  = 0;
    m_err   = 0;
    m_both  = 0;
    forever begin
      @(negedge clock);
      if (ps2_clk_oe === 1'b1) m_clkoe++;
      if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) m_start++;
      if (cmd_done === 1'b1) m_done++;
      if (cmd_error === 1'b1) m_err++;
      if (cmd_done === 1'b1 && cmd_error === 1'b1) m_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device should see it on the data line, bit k = k-th sampled bit.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic handshake(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = (cmd_ready === 1'b1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Wait for request-to-send: clock released by the host, data held low (start bit).
  task automatic wait_rts(output bit ok);
    int n;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) && n < INH + 20) begin
      @(negedge clock);
      n++;
    end
    ok = (ps2_clk_oe === 1'b0 && ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0);
  endtask

  // Device clock pulses; data sampled on each rising edge, ACK level driven from the 11th fall.
  // A stray cmd_valid pulse on the 5th pulse must be ignored by the busy host.
  task automatic device_pulses(input int count, input int half, input bit ack_lvl,
                               output logic [9:0] got);
    got = '0;
    for (int k = 1; k <= count; k++) begin
      dev_clk = 1'b0;
      if (k == 11) dev_dat = ack_lvl;
      if (k == 5) begin
        cmd_data  = ~cmd_data;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (half - 1) @(negedge clock);
      end else begin
        repeat (half) @(negedge clock);
      end
      dev_clk = 1'b1;
      if (k <= 10) got[k-1] = ps2_dat_in;
      repeat (half) @(negedge clock);
    end
    dev_dat = 1'b1;
  endtask

  task automatic run_transfer(input string tag, input logic [7:0] b, input int half,
                              input bit ack_lvl, input bit expect_done);
    bit ok;
    logic [9:0] got;
    int b_clk, b_start, b_done, b_err;
    b_clk   = m_clkoe;
    b_start = m_start;
    b_done  = m_done;
    b_err   = m_err;
    handshake(b, ok);
    check({tag, " ready"}, 32'(ok), 32'd1);
    wait_rts(ok);
    check({tag, " rts"}, 32'(ok), 32'd1);
    repeat (half) @(negedge clock);
    device_pulses(12, half, ack_lvl, got);
    repeat (20) @(negedge clock);
    check({tag, " frame"}, 32'(got), 32'(model_frame(b)));
    check({tag, " clk_oe cycles"}, 32'(m_clkoe - b_clk), 32'(INH));
    check({tag, " start overlap"}, 32'(m_start - b_start), 32'd1);
    check({tag, " done pulses"}, 32'(m_done - b_done), expect_done ? 32'd1 : 32'd0);
    check({tag, " error pulses"}, 32'(m_err - b_err), expect_done ? 32'd0 : 32'd1);
    check({tag, " idle outputs"}, {28'd0, ps2_clk_oe, ps2_dat_oe, busy, cmd_ready}, 32'h1);
    repeat (30) @(negedge clock);
    check({tag, " no retrigger"}, 32'(m_clkoe - b_clk), 32'(INH));
  endtask

  initial begin
    bit ok;
    int n;
    int b_done, b_err;
    logic [9:0] got;
    logic [7:0] rb;
    int rh;

    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    dev_clk   = 1'b1;
    dev_dat   = 1'b1;

    // Reset values.
    repeat (4) @(negedge clock);
    check("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset cmd_done", 32'(cmd_done), 32'd0);
    check("reset cmd_error", 32'(cmd_error), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Directed commands.
    run_transfer("F4", PS2_CMD_ENABLE, 15, 1'b0, 1'b1);
    run_transfer("ED", PS2_CMD_SET_LEDS, 15, 1'b0, 1'b1);
    run_transfer("FF", PS2_CMD_RESET, 10, 1'b0, 1'b1);

    // Random bytes with a randomly paced device.
    for (int t = 0; t < 4; t++) begin
      rb = 8'($urandom_range(0, 255));
      rh = int'($urandom_range(8, 20));
      run_transfer("rand", rb, rh, 1'b0, 1'b1);
    end

    // No device clock after release: error exactly ST_TO cycles after the clock is released.
    b_done = m_done;
    b_err  = m_err;
    handshake(PS2_CMD_ENABLE, ok);
    check("start_to ready", 32'(ok), 32'd1);
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < INH + 20) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (cmd_error !== 1'b1 && n < ST_TO + 50) begin
      @(negedge clock);
      n++;
    end
    check("start_to latency", 32'(n), 32'(ST_TO));
    repeat (10) @(negedge clock);
    check("start_to done", 32'(m_done - b_done), 32'd0);
    check("start_to error", 32'(m_err - b_err), 32'd1);

    // Device stops after the 4th falling edge: error BIT_TO cycles after that edge is seen.
    b_done = m_done;
    b_err  = m_err;
    handshake(PS2_CMD_SET_LEDS, ok);
    wait_rts(ok);
    check("bit_to rts", 32'(ok), 32'd1);
    repeat (15) @(negedge clock);
    device_pulses(3, 15, 1'b0, got);
    dev_clk = 1'b0;
    n = 0;
    while (cmd_error !== 1'b1 && n < BIT_TO + 50) begin
      @(negedge clock);
      n++;
      if (n == 15) dev_clk = 1'b1;
    end
    check("bit_to latency", 32'(n), 32'(BIT_TO + SYNC_LAT));
    check("bit_to oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    repeat (10) @(negedge clock);
    check("bit_to done", 32'(m_done - b_done), 32'd0);
    check("bit_to error", 32'(m_err - b_err), 32'd1);

    // Reset in the middle of the data bits (index 5 being driven).
    b_done = m_done;
    b_err  = m_err;
    handshake(PS2_CMD_SET_LEDS, ok);
    wait_rts(ok);
    check("rst rts", 32'(ok), 32'd1);
    repeat (15) @(negedge clock);
    device_pulses(6, 15, 1'b0, got);
    check("rst busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst outputs", {28'd0, ps2_clk_oe, ps2_dat_oe, busy, cmd_ready}, 32'h1);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("rst done", 32'(m_done - b_done), 32'd0);
    check("rst error", 32'(m_err - b_err), 32'd0);

    // Device answers NACK.
`ifdef PS2_TX_ACK_CHECK_EN
    run_transfer("nack", PS2_CMD_ENABLE, 12, 1'b1, 1'b0);
`else
    run_transfer("nack", PS2_CMD_ENABLE, 12, 1'b1, 1'b1);
`endif

    check("done/error exclusive", 32'(m_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
